// File: rtl/ara_pkg.sv
// ---------------------------------------------------------------------------
// ara_pkg
// Definitions shared by the ring link buffer, the slide unit and the ring
// router.
//   ELEN          : width of one vector element, which is also one ring beat
//   elen_t        : element type
//   ring_beat_t   : one beat carried on the inter-cluster ring
//   ring_ptr_inc  : FIFO pointer increment that wraps from depth-1 back to 0
// ---------------------------------------------------------------------------
package ara_pkg;

   localparam int unsigned ELEN = 64;

   typedef logic [ELEN-1:0] elen_t;
   typedef elen_t           ring_beat_t;

   // Legal range for the per-channel FIFO depth of the ring link buffer.
   localparam int unsigned RING_LINK_DEPTH_MIN = 2;
   localparam int unsigned RING_LINK_DEPTH_MAX = 16;

   // Depth need not be a power of two, so the wrap is explicit.
   function automatic int unsigned ring_ptr_inc(input int unsigned ptr,
                                                input int unsigned depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/ring_link_fifo.sv
// ---------------------------------------------------------------------------
// ring_link_fifo
// One channel of the ring link buffer: a Depth-entry valid/ready FIFO with a
// registered output side and an optional downstream-backpressure counter.
//
// Build option: define RING_LINK_PERF_EN to include the stall counter;
// without it stall_o is tied to zero and perf_clear_i is ignored.
//
// Ports
//   clk_i, rst_i   : clock, synchronous active-high reset
//   flush_i        : drop every buffered beat at the next edge
//   perf_clear_i   : clear the stall counter (wins over increment)
//   data_i/valid_i/ready_o : upstream handshake
//   data_o/valid_o/ready_i : downstream handshake
//   count_o        : current occupancy
//   stall_o        : cycles spent with valid_o && !ready_i (saturating)
// ---------------------------------------------------------------------------
module ring_link_fifo
   import ara_pkg::*;
#(
   parameter int unsigned Depth     = 2,
   parameter int unsigned DataWidth = ELEN,
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 perf_clear_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [CntWidth-1:0]  count_o,
   output logic [31:0]          stall_o
);

   localparam int unsigned PtrWidth = $clog2(Depth);

   logic [DataWidth-1:0] mem [Depth];
   logic [PtrWidth-1:0]  wr_ptr;
   logic [PtrWidth-1:0]  rd_ptr;
   logic [CntWidth-1:0]  count;
   logic                 push;
   logic                 pop;

   // Upstream readiness looks only at occupancy, flush and reset, never at
   // ready_i, so a full FIFO refuses a push even while it is being drained.
   assign ready_o = (count != CntWidth'(Depth)) && !flush_i && !rst_i;
   assign valid_o = (count != '0);
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   // Empty FIFO presents zero rather than stale storage.
   assign data_o  = valid_o ? mem[rd_ptr] : '0;
   assign count_o = count;

   // NOTE: storage is written without reset; occupancy alone decides what is
   // visible, so stale contents never escape and the array stays plain RAM.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= data_i;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= PtrWidth'(ring_ptr_inc(32'(wr_ptr), Depth));
         end
         if (pop) begin
            rd_ptr <= PtrWidth'(ring_ptr_inc(32'(rd_ptr), Depth));
         end
         unique case ({push, pop})
            2'b10:   count <= count + CntWidth'(1);
            2'b01:   count <= count - CntWidth'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef RING_LINK_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || perf_clear_i) begin
         stall_q <= '0;
      end else if (valid_o && !ready_i && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_o = stall_q;
`else
   logic unused_perf_clear;

   assign unused_perf_clear = perf_clear_i;
   assign stall_o           = '0;
`endif

endmodule

// File: rtl/ring_link_buffer.sv
// ---------------------------------------------------------------------------
// ring_link_buffer
// Elastic buffer on one hop of the inter-cluster ring. Two independent FIFOs:
// forward (left cluster ring_data_r_o -> right cluster ring_data_l_i) and
// backward (right cluster ring_data_l_o -> left cluster ring_data_r_i).
//
// Build option: define RING_LINK_PERF_EN to enable the stall counters
// (fwd_stall_o / bwd_stall_o); otherwise they read as zero.
//
// Ports
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : drop all buffered beats (ring reconfiguration)
//   fwd_*_i / fwd_*_o : forward channel handshakes, count and stall count
//   bwd_*_i / bwd_*_o : backward channel, same shape
//   perf_clear_i      : clear both stall counters
// ---------------------------------------------------------------------------
module ring_link_buffer
   import ara_pkg::*;
#(
   parameter int unsigned Depth     = 2,
   parameter int unsigned DataWidth = $bits(elen_t),
   localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,

   input  logic [DataWidth-1:0] fwd_data_i,
   input  logic                 fwd_valid_i,
   output logic                 fwd_ready_o,
   output logic [DataWidth-1:0] fwd_data_o,
   output logic                 fwd_valid_o,
   input  logic                 fwd_ready_i,

   input  logic [DataWidth-1:0] bwd_data_i,
   input  logic                 bwd_valid_i,
   output logic                 bwd_ready_o,
   output logic [DataWidth-1:0] bwd_data_o,
   output logic                 bwd_valid_o,
   input  logic                 bwd_ready_i,

   output logic [CntWidth-1:0]  fwd_count_o,
   output logic [CntWidth-1:0]  bwd_count_o,

   input  logic                 perf_clear_i,
   output logic [31:0]          fwd_stall_o,
   output logic [31:0]          bwd_stall_o
);

   if ((Depth < RING_LINK_DEPTH_MIN) || (Depth > RING_LINK_DEPTH_MAX)) begin : g_bad_depth
      $error("ring_link_buffer: Depth %0d outside legal range 2..16", Depth);
   end

   ring_link_fifo #(
      .Depth     (Depth),
      .DataWidth (DataWidth)
   ) u_fwd (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .perf_clear_i (perf_clear_i),
      .data_i       (fwd_data_i),
      .valid_i      (fwd_valid_i),
      .ready_o      (fwd_ready_o),
      .data_o       (fwd_data_o),
      .valid_o      (fwd_valid_o),
      .ready_i      (fwd_ready_i),
      .count_o      (fwd_count_o),
      .stall_o      (fwd_stall_o)
   );

   ring_link_fifo #(
      .Depth     (Depth),
      .DataWidth (DataWidth)
   ) u_bwd (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .perf_clear_i (perf_clear_i),
      .data_i       (bwd_data_i),
      .valid_i      (bwd_valid_i),
      .ready_o      (bwd_ready_o),
      .data_o       (bwd_data_o),
      .valid_o      (bwd_valid_o),
      .ready_i      (bwd_ready_i),
      .count_o      (bwd_count_o),
      .stall_o      (bwd_stall_o)
   );

endmodule

// File: tb/tb_ring_link_buffer.sv
// ---------------------------------------------------------------------------
// tb_ring_link_buffer
// Directed bench for ring_link_buffer at Depth 2, 3 and 4. Inputs change on
// the falling edge; outputs are sampled 1 ns later, before the next rising
// edge, so each record shows the state left by all previous records.
// ---------------------------------------------------------------------------
module tb_ring_link_buffer;
   import ara_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush, perf_clear;

   // ---------------- Depth 2 instance ----------------
   ring_beat_t d2_fdi, d2_fdo, d2_bdi, d2_bdo;
   logic       d2_fvi, d2_fro, d2_fvo, d2_fri;
   logic       d2_bvi, d2_bro, d2_bvo, d2_bri;
   logic [1:0] d2_fcnt, d2_bcnt;
   logic [31:0] d2_fst, d2_bst;

   ring_link_buffer #(.Depth(2)) u_d2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .fwd_data_i(d2_fdi), .fwd_valid_i(d2_fvi), .fwd_ready_o(d2_fro),
      .fwd_data_o(d2_fdo), .fwd_valid_o(d2_fvo), .fwd_ready_i(d2_fri),
      .bwd_data_i(d2_bdi), .bwd_valid_i(d2_bvi), .bwd_ready_o(d2_bro),
      .bwd_data_o(d2_bdo), .bwd_valid_o(d2_bvo), .bwd_ready_i(d2_bri),
      .fwd_count_o(d2_fcnt), .bwd_count_o(d2_bcnt),
      .perf_clear_i(perf_clear), .fwd_stall_o(d2_fst), .bwd_stall_o(d2_bst)
   );

   // ---------------- Depth 3 instance ----------------
   ring_beat_t d3_fdi, d3_fdo, d3_bdo;
   logic       d3_fvi, d3_fro, d3_fvo, d3_fri;
   logic       d3_bro, d3_bvo;
   logic [1:0] d3_fcnt, d3_bcnt;
   logic [31:0] d3_fst, d3_bst;

   ring_link_buffer #(.Depth(3)) u_d3 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .fwd_data_i(d3_fdi), .fwd_valid_i(d3_fvi), .fwd_ready_o(d3_fro),
      .fwd_data_o(d3_fdo), .fwd_valid_o(d3_fvo), .fwd_ready_i(d3_fri),
      .bwd_data_i('0), .bwd_valid_i(1'b0), .bwd_ready_o(d3_bro),
      .bwd_data_o(d3_bdo), .bwd_valid_o(d3_bvo), .bwd_ready_i(1'b1),
      .fwd_count_o(d3_fcnt), .bwd_count_o(d3_bcnt),
      .perf_clear_i(perf_clear), .fwd_stall_o(d3_fst), .bwd_stall_o(d3_bst)
   );

   // ---------------- Depth 4 instance ----------------
   ring_beat_t d4_fdi, d4_fdo, d4_bdo;
   logic       d4_fvi, d4_fro, d4_fvo, d4_fri;
   logic       d4_bro, d4_bvo;
   logic [2:0] d4_fcnt, d4_bcnt;
   logic [31:0] d4_fst, d4_bst;

   ring_link_buffer #(.Depth(4)) u_d4 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .fwd_data_i(d4_fdi), .fwd_valid_i(d4_fvi), .fwd_ready_o(d4_fro),
      .fwd_data_o(d4_fdo), .fwd_valid_o(d4_fvo), .fwd_ready_i(d4_fri),
      .bwd_data_i('0), .bwd_valid_i(1'b0), .bwd_ready_o(d4_bro),
      .bwd_data_o(d4_bdo), .bwd_valid_o(d4_bvo), .bwd_ready_i(1'b1),
      .fwd_count_o(d4_fcnt), .bwd_count_o(d4_bcnt),
      .perf_clear_i(perf_clear), .fwd_stall_o(d4_fst), .bwd_stall_o(d4_bst)
   );

   // ---------------- checking ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       rst;
      logic       flush;
      logic       vin;
      ring_beat_t din;
      logic       rdy;
      logic       exp_v;
      ring_beat_t exp_d;
      logic       exp_r;
      logic [1:0] exp_c;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

`ifdef RING_LINK_PERF_EN
   localparam logic [31:0] EXP_STALL7 = 32'd7;
`else
   localparam logic [31:0] EXP_STALL7 = 32'd0;
`endif

   initial begin
      // Depth 2 table: rst, flush, valid_i, data_i, ready_i | valid_o, data_o, ready_o, count
      // Back-to-back stream with a ready consumer: one beat per cycle, count <= 1.
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 64'h11, 1'b1,  1'b0, 64'h0,  1'b1, 2'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 64'h22, 1'b1,  1'b1, 64'h11, 1'b1, 2'd1};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'h33, 1'b1,  1'b1, 64'h22, 1'b1, 2'd1};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1,  1'b1, 64'h33, 1'b1, 2'd1};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1,  1'b0, 64'h0,  1'b1, 2'd0};
      // Stalled consumer: 0xA, 0xB stored, 0xC held until space frees.
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 64'hA,  1'b0,  1'b0, 64'h0,  1'b1, 2'd0};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'hB,  1'b0,  1'b1, 64'hA,  1'b1, 2'd1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 64'hC,  1'b0,  1'b1, 64'hA,  1'b0, 2'd2};
      // Full with a pop: push still refused.
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 64'hC,  1'b1,  1'b1, 64'hA,  1'b0, 2'd2};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 64'hC,  1'b1,  1'b1, 64'hB,  1'b1, 2'd1};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1,  1'b1, 64'hC,  1'b1, 2'd1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b1,  1'b0, 64'h0,  1'b1, 2'd0};
      // Flush beats a simultaneous push.
      vecs[12] = '{1'b0, 1'b0, 1'b1, 64'hD,  1'b0,  1'b0, 64'h0,  1'b1, 2'd0};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 64'hE,  1'b0,  1'b1, 64'hD,  1'b0, 2'd1};
      vecs[14] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0,  1'b0, 64'h0,  1'b1, 2'd0};
      // Reset with two beats buffered.
      vecs[15] = '{1'b0, 1'b0, 1'b1, 64'h66, 1'b0,  1'b0, 64'h0,  1'b1, 2'd0};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 64'h77, 1'b0,  1'b1, 64'h66, 1'b1, 2'd1};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 64'h0,  1'b0,  1'b1, 64'h66, 1'b0, 2'd2};
      vecs[18] = '{1'b0, 1'b0, 1'b0, 64'h0,  1'b0,  1'b0, 64'h0,  1'b1, 2'd0};

      rst = 1'b1; flush = 1'b0; perf_clear = 1'b0;
      d2_fdi = '0; d2_fvi = 1'b0; d2_fri = 1'b0;
      d2_bdi = '0; d2_bvi = 1'b0; d2_bri = 1'b0;
      d3_fdi = '0; d3_fvi = 1'b0; d3_fri = 1'b0;
      d4_fdi = '0; d4_fvi = 1'b0; d4_fri = 1'b0;

      // ---------------- reset ----------------
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("ready_o low during reset", {63'd0, d2_fro}, 64'd0);
      rst = 1'b0;
      #1;
      check("reset fwd valid_o", {63'd0, d2_fvo}, 64'd0);
      check("reset fwd ready_o", {63'd0, d2_fro}, 64'd1);
      check("reset fwd data_o", d2_fdo, 64'd0);
      check("reset bwd count", {62'd0, d2_bcnt}, 64'd0);
      check("reset d4 count", {61'd0, d4_fcnt}, 64'd0);

      // ---------------- Depth 2 table ----------------
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst    = vecs[i].rst;
         flush  = vecs[i].flush;
         d2_fvi = vecs[i].vin;  d2_fdi = vecs[i].din;  d2_fri = vecs[i].rdy;
         d2_bvi = vecs[i].vin;  d2_bdi = vecs[i].din;  d2_bri = vecs[i].rdy;
         #1;
         check($sformatf("v%0d fwd valid_o", i), {63'd0, d2_fvo}, {63'd0, vecs[i].exp_v});
         check($sformatf("v%0d fwd data_o", i), d2_fdo, vecs[i].exp_d);
         check($sformatf("v%0d fwd ready_o", i), {63'd0, d2_fro}, {63'd0, vecs[i].exp_r});
         check($sformatf("v%0d fwd count", i), {62'd0, d2_fcnt}, {62'd0, vecs[i].exp_c});
         check($sformatf("v%0d bwd valid_o", i), {63'd0, d2_bvo}, {63'd0, vecs[i].exp_v});
         check($sformatf("v%0d bwd data_o", i), d2_bdo, vecs[i].exp_d);
         check($sformatf("v%0d bwd ready_o", i), {63'd0, d2_bro}, {63'd0, vecs[i].exp_r});
         check($sformatf("v%0d bwd count", i), {62'd0, d2_bcnt}, {62'd0, vecs[i].exp_c});
      end
      check("d2 fwd stall after reset", {32'd0, d2_fst}, 64'd0);
      check("d2 bwd stall after reset", {32'd0, d2_bst}, 64'd0);
      rst = 1'b0; flush = 1'b0;
      d2_fvi = 1'b0; d2_bvi = 1'b0;

      // ---------------- Depth 4: fill, flush, refill ----------------
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         d4_fvi = 1'b1; d4_fdi = 64'h40 + 64'(i); d4_fri = 1'b0;
      end
      @(negedge clk);
      d4_fvi = 1'b0;
      #1;
      check("d4 full count", {61'd0, d4_fcnt}, 64'd4);
      check("d4 full ready_o", {63'd0, d4_fro}, 64'd0);
      check("d4 full head", d4_fdo, 64'h40);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("d4 flushed count", {61'd0, d4_fcnt}, 64'd0);
      check("d4 flushed valid_o", {63'd0, d4_fvo}, 64'd0);
      check("d4 flushed data_o", d4_fdo, 64'd0);
      d4_fvi = 1'b1; d4_fdi = 64'h55;
      @(negedge clk);
      d4_fvi = 1'b0;
      #1;
      check("d4 refill data_o", d4_fdo, 64'h55);
      check("d4 refill count", {61'd0, d4_fcnt}, 64'd1);

      // ---------------- stall counters ----------------
      perf_clear = 1'b1;
      @(negedge clk);
      perf_clear = 1'b0;
      #1;
      check("stall cleared before window", {32'd0, d4_fst}, 64'd0);
      repeat (7) @(negedge clk);
      #1;
      check("d4 fwd stall after 7", {32'd0, d4_fst}, {32'd0, EXP_STALL7});
      check("d4 bwd stall idle", {32'd0, d4_bst}, 64'd0);
      perf_clear = 1'b1;
      @(negedge clk);
      perf_clear = 1'b0;
      #1;
      check("d4 fwd stall cleared", {32'd0, d4_fst}, 64'd0);
      d4_fri = 1'b1;
      @(negedge clk);
      #1;
      check("d4 drained valid_o", {63'd0, d4_fvo}, 64'd0);
      check("d4 drained count", {61'd0, d4_fcnt}, 64'd0);

      // ---------------- Depth 3: random ready, pointer wraps ----------------
      begin
         int sent = 0;
         int recv = 0;
         ring_beat_t exp_beat;
         logic do_push, do_pop;
         for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
            @(negedge clk);
            d3_fvi = (sent < 10);
            d3_fdi = 64'hC0 + 64'(sent);
            d3_fri = 1'($urandom_range(0, 1));
            #1;
            do_push = d3_fvi && d3_fro;
            do_pop  = d3_fvo && d3_fri;
            check("d3 count within depth", {63'd0, (d3_fcnt <= 2'd3)}, 64'd1);
            if (do_pop) begin
               exp_beat = 64'hC0 + 64'(recv);
               check($sformatf("d3 beat %0d", recv), d3_fdo, exp_beat);
               recv++;
            end
            if (do_push) sent++;
         end
         check("d3 all beats received", 64'(recv), 64'd10);
         @(negedge clk);
         d3_fvi = 1'b0; d3_fri = 1'b1;
         #1;
         check("d3 empty at end", {63'd0, d3_fvo}, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
